// File: rtl/cacheline_burst_adapter_pkg.sv
// cacheline_burst_adapter_pkg: shared widths and the adapter state encoding
package cacheline_burst_adapter_pkg;
  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;
  localparam int BEATS_W = LINE_W / BURST_W;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adapter_state_t;
endpackage

// File: rtl/cacheline_burst_adapter.sv
// cacheline_burst_adapter: serialises cache lines into memory bursts and assembles fills
module cacheline_burst_adapter
  import cacheline_burst_adapter_pkg::*;
#(
  parameter int LINE_WIDTH  = LINE_W,
  parameter int BURST_WIDTH = BURST_W,
  parameter int ADDR_WIDTH  = ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   line_read_i,
  input  logic                   line_write_i,
  input  logic [ADDR_WIDTH-1:0]  line_addr_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic                   line_resp_o,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  input  logic                   mem_resp_i
);
  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CW = $clog2(BEATS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
  adapter_state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [LINE_WIDTH-1:0] buf_q, buf_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic last;
  assign last = count_q == CW'(BEATS - 1);
  // next state: accept requests in IDLE, step one beat per mem_resp_i while bursting
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    buf_d   = buf_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: if (line_write_i || line_read_i) begin
        state_d = line_write_i ? WRITE : READ;
        addr_d  = line_addr_i & ALIGN;
        count_d = '0;
        if (line_write_i) buf_d = line_i;
      end
      READ, WRITE: if (mem_resp_i) begin
        if (state_q == READ) buf_d[int'(count_q)*BURST_WIDTH +: BURST_WIDTH] = burst_i;
        count_d = last ? '0 : count_q + CW'(1);
        if (last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, beat counter, line buffer and burst address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
    end
  end
  // outputs decoded from registered state only
  always_comb begin
    line_o      = buf_q;
    line_resp_o = state_q == DONE;
    mem_read_o  = state_q == READ;
    mem_write_o = state_q == WRITE;
    mem_addr_o  = state_q == IDLE ? '0 : addr_q;
    burst_o     = state_q == WRITE ? buf_q[int'(count_q)*BURST_WIDTH +: BURST_WIDTH] : '0;
  end
endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// tb_cacheline_burst_adapter: directed checks of fill, write-back, gaps, priority and reset abort
module tb_cacheline_burst_adapter;
  logic clk = 0;
  logic rst_n = 0;
  logic line_read_i = 0, line_write_i = 0, mem_resp_i = 0;
  logic [31:0] line_addr_i = '0;
  logic [255:0] line_i = '0;
  logic [255:0] line_o;
  logic line_resp_o, mem_read_o, mem_write_o;
  logic [31:0] mem_addr_o;
  logic [63:0] burst_i = '0, burst_o;
  int cmps = 0, errs = 0;
  logic pat [7] = '{1, 0, 0, 1, 0, 1, 1};
  logic [255:0] wline;
  localparam logic [255:0] L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] L3 = {64'h0707_0707_0707_0707, 64'h0606_0606_0606_0606,
                                 64'h0404_0404_0404_0404, 64'h0101_0101_0101_0101};

  cacheline_burst_adapter dut (
    .clk(clk), .rst_n(rst_n), .line_read_i(line_read_i), .line_write_i(line_write_i),
    .line_addr_i(line_addr_i), .line_i(line_i), .line_o(line_o), .line_resp_o(line_resp_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .burst_i(burst_i), .burst_o(burst_o), .mem_resp_i(mem_resp_i)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_resp"}, 256'(line_resp_o), 256'(0));
    chk({tag, "_rd"}, 256'(mem_read_o), 256'(0));
    chk({tag, "_wr"}, 256'(mem_write_o), 256'(0));
    chk({tag, "_addr"}, 256'(mem_addr_o), 256'(0));
  endtask

  initial begin
    #2;
    idle_outs("rst");
    chk("rst_line", line_o, 256'(0));
    chk("rst_burst", 256'(burst_o), 256'(0));
    #10 rst_n = 1;
    tick;
    // 1: back-to-back read fill
    line_read_i = 1; line_addr_i = 32'h0000_1234;
    tick;
    line_read_i = 0; line_addr_i = 32'hFFFF_FFFF;
    chk("t1_rd", 256'(mem_read_o), 256'(1));
    chk("t1_addr", 256'(mem_addr_o), 256'h1220);
    mem_resp_i = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t1_noresp", 256'(line_resp_o), 256'(0));
      burst_i = L1[i*64 +: 64];
      tick;
    end
    mem_resp_i = 0;
    chk("t1_resp", 256'(line_resp_o), 256'(1));
    chk("t1_rd_done", 256'(mem_read_o), 256'(0));
    chk("t1_line", line_o, L1);
    tick;
    idle_outs("t1_idle");
    chk("t1_hold", line_o, L1);
    // 2: write-back, beat 0 from the LSBs
    line_write_i = 1; line_addr_i = 32'h8000_003F;
    line_i = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
    wline = line_i;
    tick;
    line_write_i = 0; line_i = '0;
    chk("t2_addr", 256'(mem_addr_o), 256'h8000_0020);
    mem_resp_i = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_wr", 256'(mem_write_o), 256'(1));
      chk("t2_beat", 256'(burst_o), 256'(wline[i*64 +: 64]));
      chk("t2_noresp", 256'(line_resp_o), 256'(0));
      tick;
    end
    mem_resp_i = 0;
    chk("t2_resp", 256'(line_resp_o), 256'(1));
    chk("t2_wr_done", 256'(mem_write_o), 256'(0));
    chk("t2_line", line_o, wline);
    tick;
    idle_outs("t2_idle");
    // 3: gapped read, gap-cycle data must be ignored
    line_read_i = 1; line_addr_i = 32'h0000_0040;
    tick;
    line_read_i = 0;
    for (int i = 0; i < 7; i++) begin
      chk("t3_rd", 256'(mem_read_o), 256'(1));
      chk("t3_noresp", 256'(line_resp_o), 256'(0));
      mem_resp_i = pat[i];
      burst_i = {8{8'(i + 1)}};
      tick;
    end
    mem_resp_i = 0;
    chk("t3_resp", 256'(line_resp_o), 256'(1));
    chk("t3_line", line_o, L3);
    tick;
    chk("t3_resp_off", 256'(line_resp_o), 256'(0));
    // 4: simultaneous read and write, write wins
    line_read_i = 1; line_write_i = 1; line_addr_i = 32'h0000_0100;
    line_i = {64'h4, 64'h3, 64'h2, 64'h1};
    tick;
    line_read_i = 0; line_write_i = 0;
    mem_resp_i = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_wr", 256'(mem_write_o), 256'(1));
      chk("t4_rd", 256'(mem_read_o), 256'(0));
      chk("t4_beat", 256'(burst_o), 256'(i + 1));
      tick;
    end
    mem_resp_i = 0;
    chk("t4_resp", 256'(line_resp_o), 256'(1));
    tick;
    // 5: async reset after two read beats
    line_read_i = 1; line_addr_i = 32'h0000_2000;
    tick;
    line_read_i = 0; mem_resp_i = 1;
    burst_i = 64'h1111_1111_1111_1111; tick;
    burst_i = 64'h2222_2222_2222_2222; tick;
    chk("t5_rd_pre", 256'(mem_read_o), 256'(1));
    rst_n = 0;
    #1;
    idle_outs("t5_rst");
    chk("t5_line", line_o, 256'(0));
    tick;
    mem_resp_i = 0;
    chk("t5_noresp", 256'(line_resp_o), 256'(0));
    rst_n = 1;
    tick;
    chk("t5_noresp2", 256'(line_resp_o), 256'(0));
    line_read_i = 1; line_addr_i = 32'h0000_2010;
    tick;
    line_read_i = 0;
    chk("t5_addr", 256'(mem_addr_o), 256'h2000);
    mem_resp_i = 1;
    for (int i = 0; i < 4; i++) begin
      burst_i = L1[i*64 +: 64];
      tick;
    end
    mem_resp_i = 0;
    chk("t5_resp", 256'(line_resp_o), 256'(1));
    chk("t5_line2", line_o, L1);
    tick;
    // 6: spurious mem_resp_i while idle
    mem_resp_i = 1; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (3) begin
      tick;
      idle_outs("t6");
      chk("t6_line", line_o, L1);
    end
    mem_resp_i = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
